// File: rtl/counter_ctrl_pkg.sv
// Shared constants for the start/stop/clear counter controller.
// Holds the FSM state encoding and the counter-width helper.
// Imported by the RTL and the testbench so both agree on encodings.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // Width of a counter that must hold values 0..n-1 (at least one bit).
  function automatic int ctr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// Button inputs and counter-control outputs of counter_ctrl.
// No latency: plain wires grouped for port hygiene.
// No backpressure: buttons are raw levels, outputs are single-cycle pulses/levels.
interface counter_ctrl_if;
  logic btn_start;
  logic btn_clear;
  logic count_en;
  logic count_clr;
  logic running;

  // Drives the buttons and observes the controller (bench / board side).
  modport master (
    output btn_start,
    output btn_clear,
    input  count_en,
    input  count_clr,
    input  running
  );

  // The controller itself.
  modport slave (
    input  btn_start,
    input  btn_clear,
    output count_en,
    output count_clr,
    output running
  );
endinterface

// File: rtl/counter_ctrl_btn_debounce.sv
// Synchronise, debounce and edge-detect one raw mechanical button.
// Latency: press pulse is registered DEBOUNCE_CYCLES+2 edges after the raw level is first sampled.
// No backpressure: emits a one-cycle press pulse per accepted 0->1 transition.
module btn_debounce
  import counter_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = ctr_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Synchroniser chain, mismatch counter and stable-level update.
  // The counter holds how many consecutive cycles the synchronised level has
  // disagreed with the stable level; the level is accepted on the cycle the
  // run length reaches DEBOUNCE_CYCLES, so shorter glitches leave no trace.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // Only a rising stable level counts as a press; release is ignored.
    press_d = stable_d & ~stable_q;
  end

  // State registers, all cleared by reset so a partial debounce is discarded.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/counter_ctrl.sv
// Start/pause/clear controller producing tick enables for a two-digit counter.
// Latency: running/count_clr change DEBOUNCE_CYCLES+3 edges after a new held button level.
// No backpressure: count_en fires once per TICK_DIV cycles in RUN; all outputs registered.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_DIV        = 50_000_000
) (
  input  logic           clock,
  input  logic           reset,
  counter_ctrl_if.slave  bus
);

  localparam int TW = ctr_width(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic start_press;
  logic clear_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_start (
    .clock   (clock),
    .reset   (reset),
    .btn_raw (bus.btn_start),
    .press   (start_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clear (
    .clock   (clock),
    .reset   (reset),
    .btn_raw (bus.btn_clear),
    .press   (clear_press)
  );

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          running_q, running_d;
  logic          count_en_q, count_en_d;
  logic          count_clr_q, count_clr_d;

  // Next-state logic; a clear press always wins over a simultaneous start press.
  always_comb begin
    state_d     = state_q;
    count_clr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_press) begin
          count_clr_d = 1'b1;
        end else if (start_press) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clear_press) begin
          state_d     = ST_IDLE;
          count_clr_d = 1'b1;
        end else if (start_press) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (clear_press) begin
          state_d     = ST_IDLE;
          count_clr_d = 1'b1;
        end else if (start_press) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Tick counter and registered outputs. The counter only advances on cycles
  // that stay in RUN, so pausing and resuming neither loses nor gains time.
  // Outputs are computed from next-state values so the flops line up with
  // the state they describe.
  always_comb begin
    tick_d = tick_q;
    if (state_d == ST_IDLE) begin
      tick_d = '0;
    end else if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
      tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);
    end
    running_d  = (state_d == ST_RUN);
    count_en_d = (state_d == ST_RUN) && (tick_d == TICK_LAST);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      running_q   <= 1'b0;
      count_en_q  <= 1'b0;
      count_clr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      running_q   <= running_d;
      count_en_q  <= count_en_d;
      count_clr_q <= count_clr_d;
    end
  end

  assign bus.running   = running_q;
  assign bus.count_en  = count_en_q;
  assign bus.count_clr = count_clr_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=5.
// Random button activity compared each cycle with a behavioural model,
// plus directed scenarios for start timing, clear, simultaneous presses and reset.
module tb_counter_ctrl;
  import counter_ctrl_pkg::*;

  localparam int D  = 4;
  localparam int TD = 5;
  localparam int HW = D + 1;

  logic clock = 1'b0;
  logic reset = 1'b0;

  counter_ctrl_if bus ();

  counter_ctrl #(.DEBOUNCE_CYCLES(D), .TICK_DIV(TD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: a button level is accepted once it has disagreed with the accepted
  // level for D consecutive synchronised samples; the controller acts on the
  // press one edge later. Elapsed running time survives pauses.
  state_e        m_state;
  int            m_elapsed;
  logic          m_ps, m_pc;
  logic          m_stab_s, m_stab_c;
  logic [HW-1:0] h_s, h_c;
  logic          m_run, m_en, m_clr;

  int clr_seen, en_seen;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_state   = ST_IDLE;
    m_elapsed = 0;
    m_ps      = 1'b0;
    m_pc      = 1'b0;
    m_stab_s  = 1'b0;
    m_stab_c  = 1'b0;
    h_s       = '0;
    h_c       = '0;
    m_run     = 1'b0;
    m_en      = 1'b0;
    m_clr     = 1'b0;
  endtask

  // h[0] is the raw level seen at the previous edge; h[1..D] are the samples
  // that have reached the debouncer window at this edge.
  task automatic deb(inout logic [HW-1:0] h, inout logic stab, input logic b, output logic press);
    logic all_diff;
    all_diff = 1'b1;
    for (int k = 1; k <= D; k++) if (h[k] == stab) all_diff = 1'b0;
    press = 1'b0;
    if (all_diff) begin
      stab  = ~stab;
      press = stab;
    end
    h = {h[HW-2:0], b};
  endtask

  task automatic model_step(input logic bs, input logic bc);
    state_e prev;
    prev  = m_state;
    m_clr = 1'b0;
    if (m_pc) begin
      m_state = ST_IDLE;
      m_clr   = 1'b1;
    end else if (m_ps) begin
      m_state = (m_state == ST_RUN) ? ST_PAUSE : ST_RUN;
    end
    if (m_state == ST_IDLE) m_elapsed = 0;
    else if (prev == ST_RUN && m_state == ST_RUN) m_elapsed++;
    m_run = (m_state == ST_RUN);
    m_en  = m_run && ((m_elapsed % TD) == TD - 1);
    deb(h_s, m_stab_s, bs, m_ps);
    deb(h_c, m_stab_c, bc, m_pc);
  endtask

  // One clock: advance the model with the levels the DUT sampled, then compare.
  task automatic step();
    @(posedge clock);
    model_step(bus.btn_start, bus.btn_clear);
    #1;
    chk("running",   bus.running,   m_run);
    chk("count_en",  bus.count_en,  m_en);
    chk("count_clr", bus.count_clr, m_clr);
    chk("en_clr_excl", bus.count_en & bus.count_clr, 0);
    if (bus.count_clr) clr_seen++;
    if (bus.count_en)  en_seen++;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    #1;
    chk("rst_running",   bus.running,   0);
    chk("rst_count_en",  bus.count_en,  0);
    chk("rst_count_clr", bus.count_clr, 0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic press_btn(input bit is_start, input int hold, input int gap);
    if (is_start) bus.btn_start = 1'b1; else bus.btn_clear = 1'b1;
    run_cycles(hold);
    bus.btn_start = 1'b0;
    bus.btn_clear = 1'b0;
    run_cycles(gap);
  endtask

  initial begin
    bus.btn_start = 1'b0;
    bus.btn_clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_running",   bus.running,   0);
    chk("reset_count_en",  bus.count_en,  0);
    chk("reset_count_clr", bus.count_clr, 0);
    reset = 1'b1;

    // Clean start press held 10 cycles: RUN at edge 7, first count_en at edge 11.
    bus.btn_start = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      step();
      if (e == 6)  chk("run_edge6",  bus.running, 0);
      if (e == 7)  chk("run_edge7",  bus.running, 1);
      if (e == 10) chk("en_edge10",  bus.count_en, 0);
      if (e == 11) chk("en_edge11",  bus.count_en, 1);
      if (e == 16) chk("en_edge16",  bus.count_en, 1);
      if (e == 10) bus.btn_start = 1'b0;
    end

    // Bouncing start (3-cycle highs) while running: no toggle until held.
    for (int b = 0; b < 2; b++) begin
      bus.btn_start = 1'b1; run_cycles(3);
      bus.btn_start = 1'b0; run_cycles(3);
    end
    chk("bounce_still_run", bus.running, 1);
    press_btn(1'b1, 10, 10);
    chk("bounce_paused", bus.running, 0);

    // Clear from PAUSE, then clear in IDLE: one count_clr each, never running.
    clr_seen = 0;
    press_btn(1'b0, 8, 8);
    chk("clr_pause_pulses", clr_seen, 1);
    clr_seen = 0;
    press_btn(1'b0, 8, 8);
    chk("clr_idle_pulses", clr_seen, 1);
    chk("clr_idle_running", bus.running, 0);

    // Simultaneous start and clear in RUN: clear only.
    press_btn(1'b1, 8, 8);
    chk("pre_both_running", bus.running, 1);
    clr_seen = 0;
    bus.btn_start = 1'b1;
    bus.btn_clear = 1'b1;
    run_cycles(8);
    bus.btn_start = 1'b0;
    bus.btn_clear = 1'b0;
    run_cycles(8);
    chk("both_clr_pulses", clr_seen, 1);
    chk("both_running", bus.running, 0);

    // Reset mid-RUN: no count_en for the following 20 cycles.
    press_btn(1'b1, 8, 2);
    reset_pulse();
    en_seen = 0;
    run_cycles(20);
    chk("post_reset_en", en_seen, 0);
    chk("post_reset_running", bus.running, 0);

    // Randomised button activity with occasional resets.
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 1) == 1) bus.btn_start = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) bus.btn_clear = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 60) == 0) reset_pulse();
      run_cycles($urandom_range(1, 10));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, consecutive cycles a synchronised button level must hold before it is accepted; legal range >= 2.
REQ-002 Parameter TICK_DIV, default 50_000_000, clock cycles per count tick; legal range >= 2.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 btn_start  input  1  raw mechanical start/stop button, active-high, asynchronous to clock, may bounce.
REQ-006 btn_clear  input  1  raw mechanical clear button, active-high, asynchronous to clock, may bounce.
REQ-007 count_en  output  1  one-cycle enable pulse to the two-digit counter, one per tick while running.
REQ-008 count_clr  output  1  one-cycle synchronous clear pulse to the two-digit counter.
REQ-009 running  output  1  high while state is RUN.

Function
REQ-010 Each button SHALL pass through a two-flop synchroniser, then a debouncer with its own stable-level register and a mismatch counter.
REQ-011 The debouncer mismatch counter SHALL clear on any cycle where the synchronised level equals the stable level, and SHALL increment otherwise.
REQ-012 The stable level SHALL take the synchronised level when the mismatch counter reaches DEBOUNCE_CYCLES; glitches shorter than DEBOUNCE_CYCLES cycles SHALL produce no effect.
REQ-013 A press SHALL be a 0->1 transition of the stable level, yielding exactly one internal press pulse; release (1->0) SHALL produce no action.
REQ-014 FSM states SHALL be IDLE (stopped, cleared), RUN and PAUSE.
REQ-015 IDLE: start press -> RUN; clear press -> stay IDLE and pulse count_clr.
REQ-016 RUN: start press -> PAUSE; clear press -> IDLE and pulse count_clr.
REQ-017 PAUSE: start press -> RUN; clear press -> IDLE and pulse count_clr.
REQ-018 Start and clear presses in the same cycle SHALL be treated as clear only.
REQ-019 The tick counter SHALL count 0..TICK_DIV-1 and wrap to 0 while in RUN, hold its value in PAUSE, and be 0 in IDLE.
REQ-020 count_en SHALL be high for exactly the one cycle in which state is RUN and the tick counter equals TICK_DIV-1.
REQ-021 A RUN->PAUSE->RUN sequence SHALL resume the tick counter from the held value, so the paused time is not lost.
REQ-022 All outputs SHALL be registered, with no combinational path from inputs.
REQ-023 running and count_clr SHALL update exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples a new, held raw button level.
REQ-024 count_en and count_clr SHALL never be high in the same cycle.

Reset
REQ-025 While reset=0, the block SHALL go to state IDLE with running=0, count_en=0 and count_clr=0.
REQ-026 While reset=0, the tick counter, mismatch counters, synchronisers and stable levels SHALL all be 0.
REQ-027 Reset asserted mid-debounce or mid-tick SHALL discard the partial count, with no press and no count_en pulse emitted after release.
REQ-028 A button held high through reset release SHALL register as a press once, after the debounce interval.

Structure
REQ-029 State encodings (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2) SHALL reside in the shared counter constants include file, used by counter_ctrl and its bench.
REQ-030 One sub-module, btn_debounce (synchroniser + debouncer + rising-edge pulse, parameter DEBOUNCE_CYCLES), SHALL be instantiated twice.
REQ-031 The tick-counter and mismatch-counter widths SHALL be derived from their parameters using $clog2.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=5)
REQ-032 Clean start press held 10 cycles -> running=1 at edge 7 after sampling; count_en pulses every 5 cycles thereafter.
REQ-033 btn_start bouncing 1,0,1,0 with high times of 3 cycles, then held high -> exactly one RUN entry; running never toggles during the bounce.
REQ-034 RUN, tick counter=2, start press -> PAUSE with no count_en; start press again -> first count_en exactly 2 cycles after resuming RUN.
REQ-035 btn_start and btn_clear rising on the same edge while in RUN -> IDLE, one count_clr pulse, running=0, no count_en.
REQ-036 reset pulsed low for 1 cycle mid-RUN at tick counter=3 -> IDLE immediately, all outputs 0, no count_en for the following 20 cycles.
REQ-037 Clear press in IDLE -> one count_clr pulse; state stays IDLE; running stays 0.
